// File: rtl/tqvp_alonso_rsa_modexp.sv
// Modular exponentiation peripheral for TinyQV: C = P^E mod M.
// Constant-time right-to-left square-and-multiply driven by a bit-serial
// interleaved modular multiplier that is shared between the two products.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ui_in[7:0]        input PMOD, readable at address 0xF
//   uo_out[7:0]       {5'b0, error, done, busy}
//   address[3:0]      register address
//   data_write        one-cycle write strobe
//   data_in[7:0]      write data
//   data_out[7:0]     combinational read data
module tqvp_alonso_rsa_modexp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MUL_R, S_MUL_B, S_NEXT
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   p_q, e_q, m_q, r_q;
  logic [WIDTH-1:0]   racc_q, b_q, esh_q, t_q;
  logic [WIDTH:0]     acc_q;
  logic [BW-1:0]      bit_q;
  logic [CW-1:0]      iter_q;
  logic               busy_q, done_q, err_q;

  logic [WIDTH-1:0]   mul_a_c;
  logic [WIDTH:0]     acc_next_c;

  // One interleaved step: acc = (2*acc + a_bit*b) mod m, keeping acc < m.
  function automatic logic [WIDTH:0] mod_step(input logic [WIDTH:0]   acc,
                                              input logic             a_bit,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH:0] t;
    logic [WIDTH:0] mm;
    mm = {1'b0, m};
    t  = acc << 1;
    if (t >= mm) t = t - mm;
    if (a_bit) begin
      t = t + {1'b0, b};
      if (t >= mm) t = t - mm;
    end
    return t;
  endfunction

  // MUL_R multiplies R_acc by B; MUL_B squares B.
  assign mul_a_c    = (state_q == S_MUL_R) ? racc_q : b_q;
  assign acc_next_c = mod_step(acc_q, mul_a_c[bit_q], b_q, m_q);

  assign uo_out = {5'b0, err_q, done_q, busy_q};

  // Register window and exponentiation sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      racc_q  <= '0;
      b_q     <= '0;
      esh_q   <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Host writes are only honoured while idle, so they never race the FSM.
      if (data_write && !busy_q) begin
        for (int k = 0; k < int'(NB); k++) begin
          if (address == 4'(1 + k)) p_q[8*k +: 8] <= data_in;
          if (address == 4'(4 + k)) e_q[8*k +: 8] <= data_in;
          if (address == 4'(7 + k)) m_q[8*k +: 8] <= data_in;
        end
        if (address == 4'h0) begin
          if (data_in[0]) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_INIT;
          end else if (data_in[1]) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
          end
        end
      end

      case (state_q)
        S_INIT: begin
          if ((m_q == '0) || (p_q >= m_q)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            racc_q  <= (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
            b_q     <= p_q;
            esh_q   <= e_q;
            iter_q  <= CW'(WIDTH);
            acc_q   <= '0;
            bit_q   <= BW'(WIDTH - 1);
            state_q <= S_MUL_R;
          end
        end
        S_MUL_R: begin
          acc_q <= acc_next_c;
          bit_q <= bit_q - 1'b1;
          if (bit_q == '0) begin
            t_q     <= acc_next_c[WIDTH-1:0];
            acc_q   <= '0;
            bit_q   <= BW'(WIDTH - 1);
            state_q <= S_MUL_B;
          end
        end
        S_MUL_B: begin
          // Final square stays in acc_q for NEXT to pick up.
          acc_q <= acc_next_c;
          bit_q <= bit_q - 1'b1;
          if (bit_q == '0) begin
            bit_q   <= BW'(WIDTH - 1);
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (esh_q[0]) racc_q <= t_q;
          b_q    <= acc_q[WIDTH-1:0];
          esh_q  <= esh_q >> 1;
          iter_q <= iter_q - 1'b1;
          acc_q  <= '0;
          if (iter_q == CW'(1)) begin
            r_q     <= esh_q[0] ? t_q : racc_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_MUL_R;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux; byte slots beyond the operand width read as zero.
  always_comb begin
    data_out = '0;
    if (address == 4'h0) data_out = {5'b0, err_q, done_q, busy_q};
    if (address == 4'hF) data_out = ui_in;
    for (int k = 0; k < int'(NB); k++) begin
      if (address == 4'(1 + k))  data_out = p_q[8*k +: 8];
      if (address == 4'(4 + k))  data_out = e_q[8*k +: 8];
      if (address == 4'(7 + k))  data_out = m_q[8*k +: 8];
      if (address == 4'(10 + k)) data_out = r_q[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_tqvp_alonso_rsa_modexp.sv
module tb_tqvp_alonso_rsa_modexp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [3:0] address;
  logic [7:0] data_in;
  logic       dw8, dw16;
  logic [7:0] uo8, uo16, do8, do16;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tqvp_alonso_rsa_modexp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo8),
    .address(address), .data_write(dw8), .data_in(data_in), .data_out(do8));

  tqvp_alonso_rsa_modexp #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16),
    .address(address), .data_write(dw16), .data_in(data_in), .data_out(do16));

  // Reference model: right-to-left square-and-multiply with native %.
  function automatic longint modexp(input longint p, input longint e, input longint m, input int w);
    longint r, b;
    r = 1 % m;
    b = p;
    for (int i = 0; i < w; i++) begin
      if ((e >> i) & 1) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r;
  endfunction

  task automatic wr(input bit sel, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    if (sel) dw16 = 1'b1; else dw8 = 1'b1;
    @(posedge clk);
    #1;
    dw8 = 1'b0;
    dw16 = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = sel ? do16 : do8;
  endtask

  function automatic logic [7:0] status(input bit sel);
    return sel ? uo16 : uo8;
  endfunction

  task automatic load(input bit sel, input logic [15:0] p, input logic [15:0] e, input logic [15:0] m);
    int nb;
    nb = sel ? 2 : 1;
    for (int k = 0; k < nb; k++) begin
      wr(sel, 4'(1 + k), p[8*k +: 8]);
      wr(sel, 4'(4 + k), e[8*k +: 8]);
      wr(sel, 4'(7 + k), m[8*k +: 8]);
    end
  endtask

  // Loads operands, queues the expected result and issues start.
  task automatic start_op(input bit sel, input logic [15:0] p, input logic [15:0] e,
                          input logic [15:0] m, input logic [15:0] exp_r);
    load(sel, p, e, m);
    sb.push_back(exp_r);
    wr(sel, 4'h0, 8'h01);
    start_cyc = cyc;
    checks++;
    if (status(sel) !== 8'h01) begin
      errors++;
      $display("FAIL busy_after_start: got %h want 01", status(sel));
    end
  endtask

  // Waits for done, checks latency and pops the scoreboard against R.
  task automatic finish_op(input bit sel, input int lat, input string tag);
    logic [7:0] b0, b1;
    logic [15:0] r, exp_r;
    while (status(sel)[1] !== 1'b1 && (cyc - start_cyc) < 2000) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ((cyc - start_cyc) !== lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", tag, cyc - start_cyc, lat);
    end
    checks++;
    if (status(sel) !== 8'h02) begin
      errors++;
      $display("FAIL %s_status: got %h want 02", tag, status(sel));
    end
    rd(sel, 4'hA, b0);
    b1 = 8'h00;
    if (sel) rd(sel, 4'hB, b1);
    r = {b1, b0};
    exp_r = sb.pop_front();
    checks++;
    if (r !== exp_r) begin
      errors++;
      $display("FAIL %s_result: got %h want %h", tag, r, exp_r);
    end
    wr(sel, 4'h0, 8'h02);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst_n = 1'b0;
    ui_in = 8'h00;
    address = 4'h0;
    data_in = 8'h00;
    dw8 = 1'b0;
    dw16 = 1'b0;
    #12;
    checks++;
    if (uo8 !== 8'h00 || uo16 !== 8'h00) begin
      errors++;
      $display("FAIL reset_uo: got %h/%h want 00", uo8, uo16);
    end
    rd(1'b0, 4'hA, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reset_r: got %h want 00", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    start_op(1'b0, 16'd4, 16'd13, 16'd197, 16'd26);
    finish_op(1'b0, 137, "basic");
  endtask

  task automatic test_error;
    logic [7:0] v;
    for (int i = 0; i < 2; i++) begin
      load(1'b0, 16'd200, 16'd5, (i == 0) ? 16'd197 : 16'd0);
      wr(1'b0, 4'h0, 8'h01);
      @(posedge clk);
      #1;
      checks++;
      if (uo8 !== 8'h06) begin
        errors++;
        $display("FAIL error_flags_%0d: got %h want 06", i, uo8);
      end
      rd(1'b0, 4'h0, v);
      checks++;
      if (v !== 8'h06) begin
        errors++;
        $display("FAIL error_status_%0d: got %h want 06", i, v);
      end
      rd(1'b0, 4'hA, v);
      checks++;
      if (v !== 8'd26) begin
        errors++;
        $display("FAIL error_r_kept_%0d: got %h want 1a", i, v);
      end
      wr(1'b0, 4'h0, 8'h02);
      rd(1'b0, 4'h0, v);
      checks++;
      if (v !== 8'h00) begin
        errors++;
        $display("FAIL error_clear_%0d: got %h want 00", i, v);
      end
    end
  endtask

  task automatic test_back_to_back;
    start_op(1'b0, 16'd3, 16'd196, 16'd197, 16'd1);
    finish_op(1'b0, 137, "fermat");
    start_op(1'b0, 16'd3, 16'd0, 16'd197, 16'd1);
    finish_op(1'b0, 137, "e_zero");
    start_op(1'b0, 16'd0, 16'd5, 16'd1, 16'd0);
    finish_op(1'b0, 137, "m_one");
  endtask

  task automatic test_busy_ignore;
    logic [7:0] v;
    ui_in = 8'hA5;
    start_op(1'b0, 16'd7, 16'd11, 16'd227, 16'(modexp(7, 11, 227, 8)));
    wr(1'b0, 4'h1, 8'h55);
    wr(1'b0, 4'h0, 8'h01);
    wr(1'b0, 4'h0, 8'h02);
    checks++;
    if (uo8 !== 8'h01) begin
      errors++;
      $display("FAIL busy_clear_ignored: got %h want 01", uo8);
    end
    rd(1'b0, 4'hD, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL read_0xd: got %h want 00", v);
    end
    rd(1'b0, 4'hF, v);
    checks++;
    if (v !== 8'hA5) begin
      errors++;
      $display("FAIL read_ui_in: got %h want a5", v);
    end
    finish_op(1'b0, 137, "busy");
    rd(1'b0, 4'h1, v);
    checks++;
    if (v !== 8'h07) begin
      errors++;
      $display("FAIL busy_p_kept: got %h want 07", v);
    end
  endtask

  task automatic test_width16;
    logic [7:0] v;
    start_op(1'b1, 16'h1234, 16'h0101, 16'hFFF1, 16'(modexp(64'h1234, 64'h0101, 64'hFFF1, 16)));
    finish_op(1'b1, 529, "w16");
    rd(1'b1, 4'hC, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL w16_read_0xc: got %h want 00", v);
    end
    rd(1'b1, 4'h3, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL w16_read_0x3: got %h want 00", v);
    end
  endtask

  task automatic test_abort;
    logic [7:0] v;
    start_op(1'b0, 16'd4, 16'd13, 16'd197, 16'd26);
    void'(sb.pop_front());
    repeat (49) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo8 !== 8'h00) begin
      errors++;
      $display("FAIL abort_uo: got %h want 00", uo8);
    end
    rd(1'b0, 4'hA, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL abort_r: got %h want 00", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 16'd4, 16'd13, 16'd197, 16'd26);
    finish_op(1'b0, 137, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_back_to_back();
    test_busy_ignore();
    test_width16();
    test_abort();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tqvp_alonso_rsa_modexp.md
Name: tqvp_alonso_rsa_modexp

Overview:
Byte-addressed TinyQV peripheral computing C = P^E mod M on WIDTH-bit unsigned operands. It uses constant-time right-to-left square-and-multiply built on a bit-serial interleaved modular multiplier. The CPU loads P, E and M through the 4-bit register window, writes start, and polls status or watches the PMOD flags. It then reads the result bytes.

Parameters:
WIDTH, 8, operand width in bits; legal values 8, 16, 24; NB = WIDTH/8 bytes per operand.

Ports:
clk  input  1  project clock (64 MHz nominal)
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
ui_in  input  8  input PMOD (synchronised upstream); readable at 0xF, otherwise unused
uo_out  output  8  [0]=busy, [1]=done, [2]=error, [7:3]=0
address  input  4  register address
data_write  input  1  write strobe, one cycle per write
data_in  input  8  write data, valid with data_write
data_out  output  8  read data, combinational from address

Behaviour:
- Register map (byte k little-endian, k < NB):
  - 0x0 CTRL/STATUS. Write: bit0=start, bit1=clear done/error. Read: {5'b0, error, done, busy}.
  - 0x1-0x3: P.
  - 0x4-0x6: E.
  - 0x7-0x9: M.
  - 0xA-0xC: R, read-only.
  - 0xD-0xE: read 0.
  - 0xF: ui_in.
  - Byte slots k >= NB read 0; writes to them are ignored.
- Reset (async): all registers 0, state IDLE, busy=done=error=0, uo_out=0.
- Writes to P/E/M while busy are ignored. Start while busy is ignored. Clear while busy is ignored.
- start and clear in the same write: start wins. done and error are cleared on start acceptance.
- State machine: IDLE -> INIT -> {MUL_R -> MUL_B -> NEXT} x WIDTH -> IDLE.
  - Edge 0: start sampled in IDLE. busy=1, state INIT.
  - INIT (1 cycle):
    - If M==0 or P>=M: error=1, done=1, busy=0, R unchanged, go to IDLE.
    - Else: R_acc = (M==1) ? 0 : 1, B = P, E_sh = E, iteration count = WIDTH, go to MUL_R.
  - MUL_R (WIDTH cycles): T = R_acc*B mod M.
  - MUL_B (WIDTH cycles): B' = B*B mod M, using the B from before this iteration.
  - NEXT (1 cycle):
    - If E_sh[0], R_acc = T. B = B'. E_sh >>= 1. Count decrements.
    - At count 0: R register = R_acc, done=1, busy=0, go to IDLE.
- Both products are always computed, so timing is independent of E. done rises on edge 1 + WIDTH*(2*WIDTH+1) after the start edge. For WIDTH=8 that is edge 137.
- Modular multiply a*b mod m: acc is WIDTH+1 bits, init 0, one bit per cycle, a scanned MSB first.
  - acc = 2*acc; if acc >= m, subtract m.
  - If a[i], acc += b; if acc >= m, subtract m.
  - Invariant acc < m. No intermediate exceeds 2m.
- R holds the previous result until a new successful completion.
- Reset mid-operation aborts immediately. R returns to 0 and flags clear.

Test Plan:
- WIDTH=8, P=4, E=13, M=197, start -> busy=1 next cycle; done=1 at edge 137; R=0x1A (26); uo_out=0x02.
- WIDTH=8, P=3, E=196, M=197 (Fermat) -> R=1. Then E=0 -> R=1. Then M=1, P=0, E=5 -> R=0. Each run takes 137 cycles.
- WIDTH=8, P=200, M=197, start -> error=1 and done=1 at edge 1; R unchanged; STATUS reads 0x06. Write clear -> STATUS reads 0x00. Repeat with M=0 -> same error.
- During busy: write P=0x55 and a second start -> ignored; result matches the original operands. Read 0xD -> 0; read 0xF -> ui_in.
- WIDTH=16, P=0x1234, E=0x0101, M=0xFFF1 -> R matches a software model; done at edge 529; bytes 0xC and 0x3 read 0.
- Assert rst_n low at cycle 50 of a run -> all outputs 0 asynchronously. After release, a fresh start completes correctly.
